// File: rtl/uart_xcvr.sv
// uart_xcvr: full-duplex UART with configurable frame format, baud divisor and valid/ready byte streams.
// Define UART_RX_FIFO_EN to replace the single RX output register with a first-word-fall-through FIFO.
module uart_xcvr #(
  parameter int CLKS_PER_BIT  = 434,
  parameter int DATA_BITS     = 8,
  parameter int PARITY        = 0,
  parameter int STOP_BITS     = 1,
  parameter int RX_FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun,
  output logic                 tx_busy,
  output logic                 rx_busy
);

  localparam int CW = $clog2(STOP_BITS*CLKS_PER_BIT+1);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT-1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT/2-1);
  localparam logic [CW-1:0] STOP_END = CW'(STOP_BITS*CLKS_PER_BIT-1);
  localparam logic [3:0]    LAST_BIT = 4'(DATA_BITS-1);
  localparam logic          ODD      = (PARITY == 2);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_WAIT} state_t;

  // ---------------- TX ----------------
  state_t                 tx_st;
  logic [CW-1:0]          tx_cnt;
  logic [3:0]             tx_bit;
  logic [DATA_BITS-1:0]   tx_sh;
  logic                   tx_par;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_st    <= S_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      tx_par   <= 1'b0;
      txd      <= 1'b1;
      tx_ready <= 1'b1;
      tx_busy  <= 1'b0;
    end else begin
      tx_cnt <= tx_cnt + 1'b1;
      case (tx_st)
        S_IDLE: begin
          tx_cnt <= '0;
          if (tx_valid && tx_ready) begin
            tx_sh    <= tx_data;
            tx_par   <= (^tx_data) ^ ODD;
            txd      <= 1'b0;
            tx_ready <= 1'b0;
            tx_busy  <= 1'b1;
            tx_st    <= S_START;
          end
        end
        S_START: if (tx_cnt == BIT_END) begin
          tx_cnt <= '0;
          tx_bit <= '0;
          txd    <= tx_sh[0];
          tx_sh  <= tx_sh >> 1;
          tx_st  <= S_DATA;
        end
        S_DATA: if (tx_cnt == BIT_END) begin
          tx_cnt <= '0;
          tx_bit <= tx_bit + 1'b1;
          if (tx_bit == LAST_BIT) begin
            if (PARITY != 0) begin
              txd   <= tx_par;
              tx_st <= S_PAR;
            end else begin
              txd   <= 1'b1;
              tx_st <= S_STOP;
            end
          end else begin
            txd   <= tx_sh[0];
            tx_sh <= tx_sh >> 1;
          end
        end
        S_PAR: if (tx_cnt == BIT_END) begin
          tx_cnt <= '0;
          txd    <= 1'b1;
          tx_st  <= S_STOP;
        end
        S_STOP: if (tx_cnt == STOP_END) begin
          tx_ready <= 1'b1;
          tx_busy  <= 1'b0;
          tx_st    <= S_IDLE;
        end
        default: tx_st <= S_IDLE;
      endcase
    end
  end

  // ---------------- RX ----------------
  logic                 rxd_m, rxd_s;
  state_t               rx_st;
  logic [CW-1:0]        rx_cnt;
  logic [3:0]           rx_bit;
  logic [DATA_BITS-1:0] rx_sh;
  logic                 rx_perr_r;
  logic                 rx_push;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
    end
  end

  // Completed word is handed to the delivery stage on the mid-stop sample.
  assign rx_push = (rx_st == S_STOP) && (rx_cnt == BIT_END);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_st     <= S_IDLE;
      rx_cnt    <= '0;
      rx_bit    <= '0;
      rx_sh     <= '0;
      rx_perr_r <= 1'b0;
      rx_busy   <= 1'b0;
    end else begin
      rx_cnt <= rx_cnt + 1'b1;
      case (rx_st)
        S_IDLE: begin
          rx_cnt <= '0;
          if (!rxd_s) begin
            rx_perr_r <= 1'b0;
            rx_busy   <= 1'b1;
            rx_st     <= S_START;
          end
        end
        S_START: if (rx_cnt == HALF_END) begin
          rx_cnt <= '0;
          rx_bit <= '0;
          if (rxd_s) begin
            rx_busy <= 1'b0;
            rx_st   <= S_IDLE;
          end else begin
            rx_st <= S_DATA;
          end
        end
        S_DATA: if (rx_cnt == BIT_END) begin
          rx_cnt <= '0;
          rx_bit <= rx_bit + 1'b1;
          rx_sh  <= {rxd_s, rx_sh[DATA_BITS-1:1]};
          if (rx_bit == LAST_BIT) rx_st <= (PARITY != 0) ? S_PAR : S_STOP;
        end
        S_PAR: if (rx_cnt == BIT_END) begin
          rx_cnt    <= '0;
          rx_perr_r <= ((^rx_sh) ^ ODD) != rxd_s;
          rx_st     <= S_STOP;
        end
        S_STOP: if (rx_cnt == BIT_END) begin
          // A low stop bit may be a break; hold off until the line idles.
          if (rxd_s) begin
            rx_busy <= 1'b0;
            rx_st   <= S_IDLE;
          end else begin
            rx_st <= S_WAIT;
          end
        end
        S_WAIT: if (rxd_s) begin
          rx_busy <= 1'b0;
          rx_st   <= S_IDLE;
        end
        default: rx_st <= S_IDLE;
      endcase
    end
  end

`ifdef UART_RX_FIFO_EN
  localparam int AW = $clog2(RX_FIFO_DEPTH);
  logic [DATA_BITS+1:0] mem [RX_FIFO_DEPTH];
  logic [AW-1:0]        wp, rp;
  logic [AW:0]          cnt;
  logic                 full, pop, wr;

  assign full = cnt == (AW+1)'(RX_FIFO_DEPTH);
  assign pop  = (cnt != '0) && rx_ready;
  assign wr   = rx_push && (!full || pop);

  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= {rx_sh, rx_perr_r, !rxd_s};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp         <= '0;
      rp         <= '0;
      cnt        <= '0;
      rx_overrun <= 1'b0;
    end else begin
      if (wr)  wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt        <= cnt + (AW+1)'(wr) - (AW+1)'(pop);
      rx_overrun <= rx_push && full && !pop;
    end
  end

  assign rx_valid = cnt != '0;
  assign {rx_data, rx_parity_err, rx_frame_err} = rx_valid ? mem[rp] : '0;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      rx_overrun <= 1'b0;
      if (rx_push && (!rx_valid || rx_ready)) begin
        rx_data       <= rx_sh;
        rx_parity_err <= rx_perr_r;
        rx_frame_err  <= !rxd_s;
        rx_valid      <= 1'b1;
      end else begin
        if (rx_push)  rx_overrun <= 1'b1;
        if (rx_ready) rx_valid   <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_uart_xcvr.sv
// tb_uart_xcvr: scoreboard bench for uart_xcvr with an 8N1 and a 7E1 instance, both at 4 clocks per bit.
module tb_uart_xcvr;
  localparam int CPB = 4;
`ifdef UART_RX_FIFO_EN
  localparam int OVR_WORDS = 5;
`else
  localparam int OVR_WORDS = 2;
`endif
  localparam int KEPT = OVR_WORDS - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] tx_data8, rx_data8;
  logic       tx_valid8, tx_ready8, txd8, rxd8, rx_valid8, rx_ready8;
  logic       perr8, ferr8, ovr8_o, txb8, rxb8;
  logic [6:0] tx_data7, rx_data7;
  logic       tx_valid7, tx_ready7, txd7, rxd7, rx_valid7, rx_ready7;
  logic       perr7, ferr7, ovr7_o, txb7, rxb7;

  logic loop8 = 1'b0, drv8 = 1'b1, drv7 = 1'b1;
  assign rxd8 = loop8 ? txd8 : drv8;
  assign rxd7 = drv7;

  uart_xcvr #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .RX_FIFO_DEPTH(4)) u8 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data8), .tx_valid(tx_valid8), .tx_ready(tx_ready8),
    .txd(txd8), .rxd(rxd8), .rx_data(rx_data8), .rx_valid(rx_valid8), .rx_ready(rx_ready8),
    .rx_parity_err(perr8), .rx_frame_err(ferr8), .rx_overrun(ovr8_o), .tx_busy(txb8), .rx_busy(rxb8));

  uart_xcvr #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1), .RX_FIFO_DEPTH(4)) u7 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data7), .tx_valid(tx_valid7), .tx_ready(tx_ready7),
    .txd(txd7), .rxd(rxd7), .rx_data(rx_data7), .rx_valid(rx_valid7), .rx_ready(rx_ready7),
    .rx_parity_err(perr7), .rx_frame_err(ferr7), .rx_overrun(ovr7_o), .tx_busy(txb7), .rx_busy(rxb7));

  int total = 0, bad = 0, pops8 = 0, ovr8 = 0;
  logic [9:0] q8[$];
  logic [8:0] q7[$];
  logic [9:0] e8;
  logic [8:0] e7;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Received words are checked against the scoreboard at the handshake.
  always @(negedge clk) if (rst_n) begin
    if (ovr8_o) ovr8++;
    if (rx_valid8 && rx_ready8) begin
      pops8++;
      chk("rx8_queued", 32'(q8.size() != 0), 1);
      if (q8.size() != 0) begin
        e8 = q8.pop_front();
        chk("rx8_word", {rx_data8, perr8, ferr8}, e8);
      end
    end
    if (rx_valid7 && rx_ready7) begin
      chk("rx7_queued", 32'(q7.size() != 0), 1);
      if (q7.size() != 0) begin
        e7 = q7.pop_front();
        chk("rx7_word", {rx_data7, perr7, ferr7}, e7);
      end
    end
  end

  task automatic tx8(input logic [7:0] d);
    logic [9:0] fr;
    int n;
    fr = {1'b1, d, 1'b0};
    n = 0;
    while (!tx_ready8 && n < 200) begin tick(1); n++; end
    chk("tx8_ready_wait", tx_ready8, 1);
    tx_data8 = d; tx_valid8 = 1'b1;
    tick(1);
    tx_valid8 = 1'b0;
    chk("tx8_ready_low", tx_ready8, 0);
    chk("tx8_busy", txb8, 1);
    for (int b = 0; b < 10; b++)
      for (int c = 0; c < CPB; c++) begin
        chk($sformatf("tx8_bit%0d", b), txd8, fr[b]);
        tick(1);
      end
    chk("tx8_ready_back", tx_ready8, 1);
  endtask

  task automatic tx7(input logic [6:0] d, input logic par);
    int n;
    n = 0;
    while (!tx_ready7 && n < 200) begin tick(1); n++; end
    chk("tx7_ready_wait", tx_ready7, 1);
    tx_data7 = d; tx_valid7 = 1'b1;
    tick(1);
    tx_valid7 = 1'b0;
    tick(33);  // middle of the parity bit (cycles 33..36 after handshake)
    chk("tx7_parity", txd7, par);
  endtask

  task automatic drive(input int sel, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      if (sel == 7) drv7 = bits[i]; else drv8 = bits[i];
      tick(CPB);
    end
  endtask

  task automatic wait_q8(input int budget);
    int n;
    n = 0;
    while (q8.size() != 0 && n < budget) begin tick(1); n++; end
    chk("rx8_drain", q8.size(), 0);
  endtask

  task automatic wait_q7(input int budget);
    int n;
    n = 0;
    while (q7.size() != 0 && n < budget) begin tick(1); n++; end
    chk("rx7_drain", q7.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int p0, o0;
    logic [7:0] pat [5];
    logic [7:0] d;
    pat = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81};
    tx_data8 = '0; tx_valid8 = 1'b0; rx_ready8 = 1'b1;
    tx_data7 = '0; tx_valid7 = 1'b0; rx_ready7 = 1'b1;
    rst_n = 1'b0;
    tick(3);
    chk("rst_txd", txd8, 1);
    chk("rst_tx_ready", tx_ready8, 1);
    chk("rst_rx_valid", rx_valid8, 0);
    chk("rst_rx_data", rx_data8, 0);
    chk("rst_perr", perr8, 0);
    chk("rst_ferr", ferr8, 0);
    chk("rst_ovr", ovr8_o, 0);
    chk("rst_tx_busy", txb8, 0);
    chk("rst_rx_busy", rxb8, 0);
    rst_n = 1'b1;
    tick(2);

    // 8N1 loopback, back-to-back words
    loop8 = 1'b1;
    foreach (pat[i]) begin
      q8.push_back({pat[i], 2'b00});
      tx8(pat[i]);
    end
    wait_q8(200);
    loop8 = 1'b0;

    // 7E1 transmit parity bit
    tx7(7'h55, 1'b0);
    tx7(7'h54, 1'b1);

    // 7E1 receive: wrong parity then correct parity
    q7.push_back({7'h55, 1'b1, 1'b0});
    drive(7, 16'({1'b1, 1'b1, 7'h55, 1'b0}), 10);
    q7.push_back({7'h2A, 1'b0, 1'b0});
    drive(7, 16'({1'b1, 1'b1, 7'h2A, 1'b0}), 10);
    drv7 = 1'b1;
    wait_q7(100);

    // Framing error followed by a held-low line
    p0 = pops8;
    q8.push_back({8'h3C, 1'b0, 1'b1});
    drive(8, 16'({1'b0, 8'h3C, 1'b0}), 10);
    tick(50);
    chk("ferr_one_word", pops8 - p0, 1);
    chk("ferr_wait_busy", rxb8, 1);
    drv8 = 1'b1;
    tick(8);
    chk("ferr_idle", rxb8, 0);
    chk("ferr_no_second", pops8 - p0, 1);
    chk("ferr_q_empty", q8.size(), 0);

    // One-cycle glitch is a false start
    p0 = pops8;
    drv8 = 1'b0;
    tick(1);
    drv8 = 1'b1;
    tick(20);
    chk("glitch_pops", pops8 - p0, 0);
    chk("glitch_idle", rxb8, 0);

    // Overrun with consumer stalled
    rx_ready8 = 1'b0;
    p0 = pops8;
    o0 = ovr8;
    for (int i = 0; i < OVR_WORDS; i++) begin
      d = 8'(8'h11 * (i + 1));
      if (i < KEPT) q8.push_back({d, 2'b00});
      drive(8, 16'({1'b1, d, 1'b0}), 10);
    end
    drv8 = 1'b1;
    tick(10);
    chk("ovr_pulses", ovr8 - o0, 1);
    chk("ovr_held_valid", rx_valid8, 1);
    chk("ovr_no_pop", pops8 - p0, 0);
    rx_ready8 = 1'b1;
    wait_q8(50);
    tick(2);
    chk("ovr_kept", pops8 - p0, KEPT);
    chk("ovr_drained", rx_valid8, 0);

    // Reset in the middle of a TX frame
    tx_data8 = 8'h5A; tx_valid8 = 1'b1;
    tick(1);
    tx_valid8 = 1'b0;
    tick(6);
    chk("rst_mid_txd_pre", txd8, 0);
    chk("rst_mid_busy_pre", txb8, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_txd", txd8, 1);
    chk("rst_mid_ready", tx_ready8, 1);
    tick(2);
    chk("rst_mid_txd_hold", txd8, 1);
    rst_n = 1'b1;
    tick(2);
    loop8 = 1'b1;
    q8.push_back({8'hC3, 2'b00});
    tx8(8'hC3);
    wait_q8(100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
